// File: rtl/ssd_pkg.sv
// Shared types and seven-segment glyphs for the BCD display scanner.
// Glyphs are active-high, bit 6 = segment a down to bit 0 = segment g.
package ssd_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam int POW10_W = 40;

  function automatic logic [POW10_W-1:0] pow10(input int n);
    logic [POW10_W-1:0] r;
    r = POW10_W'(1);
    for (int i = 0; i < n; i++) begin
      r = r * POW10_W'(10);
    end
    return r;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per clock.
// valid marks the cycle performing the last step; bcd then carries the final result.
module bin2bcd_seq #(
  parameter int VALUE_W = 14,
  parameter int BCD_N   = (VALUE_W + 2) / 3
) (
  input  logic                 board_clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [VALUE_W-1:0]   bin,
  output logic                 busy,
  output logic                 valid,
  output logic [4*BCD_N-1:0]   bcd
);

  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(VALUE_W - 1);

  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [VALUE_W-1:0]  sh_q, sh_d;
  logic [4*BCD_N-1:0]  bcd_q, bcd_d;
  logic [4*BCD_N-1:0]  adj;
  logic [4*BCD_N-1:0]  step;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_N; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
    end
    step  = {adj[4*BCD_N-2:0], sh_q[VALUE_W-1]};
    valid = busy_q && (cnt_q == LAST_STEP);
    bcd   = step;

    busy_d = busy_q;
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    bcd_d  = bcd_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      sh_d   = bin;
      bcd_d  = '0;
    end else if (busy_q) begin
      sh_d  = sh_q << 1;
      bcd_d = step;
      cnt_d = cnt_q + CNT_W'(1);
      if (valid) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge board_clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge board_clk) begin
    sh_q  <= sh_d;
    bcd_q <= bcd_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/ssd_bcd_scanner.sv
// N-digit multiplexed seven-segment driver showing an unsigned value in decimal,
// with leading-zero blanking, per-digit decimal points and dash-on-overflow.
module ssd_bcd_scanner
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int VALUE_W     = 14,
  parameter int REFRESH_DIV = 18,
  parameter int ACTIVE_LOW  = 1,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  board_clk,
  input  logic                  reset,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic                  blank_all,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] anodes,
  output logic [7:0]            segs
);

  localparam int BCD_N  = (VALUE_W + 2) / 3;
  localparam int DISP_W = 4 * NUM_DIGITS;
  localparam int EXT_W  = 4 * ((BCD_N > NUM_DIGITS) ? BCD_N : NUM_DIGITS);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [POW10_W-1:0] OVF_LIMIT = pow10(NUM_DIGITS) - POW10_W'(1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [7:0]            SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  state_t                state_q, state_d;
  logic                  pend_q, pend_d;
  logic [VALUE_W-1:0]    pend_val_q, pend_val_d;
  logic [VALUE_W-1:0]    val_q, val_d;
  logic [DISP_W-1:0]     disp_q, disp_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic [REFRESH_DIV-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
  logic [7:0]            segs_q, segs_d;

  logic                  eng_start;
  logic [VALUE_W-1:0]    eng_bin;
  logic                  eng_busy;
  logic                  eng_valid;
  logic [4*BCD_N-1:0]    eng_bcd;
  logic [EXT_W-1:0]      eng_ext;

  bin2bcd_seq #(
    .VALUE_W (VALUE_W),
    .BCD_N   (BCD_N)
  ) u_bin2bcd (
    .board_clk (board_clk),
    .reset     (reset),
    .start     (eng_start),
    .bin       (eng_bin),
    .busy      (eng_busy),
    .valid     (eng_valid),
    .bcd       (eng_bcd)
  );

  assign eng_ext = EXT_W'(eng_bcd);

  // Control FSM: a fresh load always beats the pending slot when a new conversion starts.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    val_d      = val_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    eng_start  = 1'b0;
    eng_bin    = value;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          eng_start = 1'b1;
          val_d     = value;
          state_d   = ST_CONV;
        end else if (pend_q) begin
          eng_start = 1'b1;
          eng_bin   = pend_val_q;
          val_d     = pend_val_q;
          pend_d    = 1'b0;
          state_d   = ST_CONV;
        end
      end
      ST_CONV: begin
        if (eng_valid) begin
          disp_d = eng_ext[DISP_W-1:0];
          ovf_d  = POW10_W'(val_q) > OVF_LIMIT;
          done_d = 1'b1;
          if (load) begin
            eng_start = 1'b1;
            val_d     = value;
          end else if (pend_q) begin
            eng_start = 1'b1;
            eng_bin   = pend_val_q;
            val_d     = pend_val_q;
            pend_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (load) begin
          pend_d     = 1'b1;
          pend_val_d = value;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_CONV);
  end

  always_comb begin
    cnt_d = cnt_q + REFRESH_DIV'(1);
    idx_d = idx_q;
    if (&cnt_q) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  logic [NUM_DIGITS-1:0] zero_from;
  logic                  all_zero;
  logic [3:0]            cur_digit;
  logic                  cur_blank;
  logic                  cur_dp;
  logic [6:0]            glyph_sel;
  logic [7:0]            seg_on;
  logic [NUM_DIGITS-1:0] an_on;

  // Pin drive is computed from the next display state so new digits appear with done.
  always_comb begin
    zero_from = '0;
    all_zero  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero     = all_zero && (disp_d[4*i +: 4] == 4'd0);
      zero_from[i] = all_zero;
    end
    cur_digit = '0;
    cur_blank = 1'b0;
    cur_dp    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_digit = disp_d[4*i +: 4];
        cur_blank = (BLANK_LZ != 0) && !ovf_d && (i > 0) && zero_from[i];
        cur_dp    = dp_mask[i];
      end
    end
    if (ovf_d) begin
      glyph_sel = SEG_DASH;
    end else if (cur_blank) begin
      glyph_sel = SEG_BLANK;
    end else begin
      glyph_sel = glyph(cur_digit);
    end
    seg_on = {glyph_sel, cur_dp && !cur_blank};
    an_on  = '0;
    if (!blank_all && !cur_blank) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_on[i] = (idx_q == IDX_W'(i));
      end
    end
    segs_d   = (ACTIVE_LOW != 0) ? ~seg_on : seg_on;
    anodes_d = (ACTIVE_LOW != 0) ? ~an_on : an_on;
  end

  always_ff @(posedge board_clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pend_q   <= 1'b0;
      disp_q   <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      anodes_q <= AN_OFF;
      segs_q   <= SEG_OFF;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      disp_q   <= disp_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      anodes_q <= anodes_d;
      segs_q   <= segs_d;
    end
  end

  always_ff @(posedge board_clk) begin
    val_q      <= val_d;
    pend_val_q <= pend_val_d;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign anodes   = anodes_q;
  assign segs     = segs_q;

endmodule

// File: tb/tb_ssd_bcd_scanner.sv
// Self-checking bench for ssd_bcd_scanner: vector table, scoreboard of committed values,
// and hand-written sequences for latency, pending overwrite, reset abort and dp/blanking.
module tb_ssd_bcd_scanner;

  localparam int ND = 4;
  localparam int VW = 14;
  localparam int RD = 3;

  logic          board_clk = 1'b0;
  logic          reset = 1'b1;
  logic [VW-1:0] value = '0;
  logic          load = 1'b0;
  logic [ND-1:0] dp_mask = '0;
  logic          blank_all = 1'b0;
  logic          busy, done, overflow;
  logic [ND-1:0] anodes;
  logic [7:0]    segs;

  always #5 board_clk = ~board_clk;

  ssd_bcd_scanner #(
    .NUM_DIGITS  (ND),
    .VALUE_W     (VW),
    .REFRESH_DIV (RD),
    .ACTIVE_LOW  (1),
    .BLANK_LZ    (1)
  ) dut (
    .board_clk (board_clk),
    .reset     (reset),
    .value     (value),
    .load      (load),
    .dp_mask   (dp_mask),
    .blank_all (blank_all),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .anodes    (anodes),
    .segs      (segs)
  );

  typedef struct {
    int unsigned val;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  exp_t        vecs[10];
  int          ntests = 0;
  int          nfails = 0;
  int          done_cnt = 0;
  logic [7:0]  glyph_lut [0:9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    ntests++;
    if (act !== req) begin
      nfails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge board_clk) begin
    if (!reset && done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        ntests++;
        nfails++;
        $display("FAIL spurious_done: got done=1, expected no commit");
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("commit_overflow_%0d", mon_e.val), {31'd0, overflow}, {31'd0, mon_e.ovf});
      end
    end
  end

  task automatic do_load(input int unsigned v, input logic ovf, input logic overwrite);
    exp_t e;
    e.val = v;
    e.ovf = ovf;
    @(negedge board_clk);
    value = VW'(v);
    load  = 1'b1;
    if (overwrite && sb.size() > 0) sb[sb.size()-1] = e;
    else sb.push_back(e);
    @(negedge board_clk);
    load = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge board_clk);
      n++;
    end
    ntests++;
    if (done !== 1'b1) begin
      nfails++;
      $display("FAIL %s_timeout: got no done in %0d cycles, expected done", name, n);
    end
  endtask

  task automatic check_display(input int unsigned v);
    logic [7:0]  exp_seg [ND];
    logic [7:0]  seen [ND];
    logic        exp_lit [ND];
    int          lit_cnt [ND];
    int unsigned pw;
    int          multi;
    int          active;
    logic        o;
    o  = (v > 9999);
    pw = 1;
    for (int k = 0; k < ND; k++) begin
      exp_lit[k] = o || (k == 0) || (v >= pw);
      exp_seg[k] = o ? 8'b11111101 : glyph_lut[(v / pw) % 10];
      if (dp_mask[k]) exp_seg[k][0] = 1'b0;
      seen[k]    = exp_seg[k];
      lit_cnt[k] = 0;
      pw         = pw * 10;
    end
    multi = 0;
    repeat (32) begin
      @(negedge board_clk);
      active = 0;
      for (int k = 0; k < ND; k++) begin
        if (anodes[k] == 1'b0) begin
          active++;
          lit_cnt[k]++;
          if (segs !== exp_seg[k]) seen[k] = segs;
        end
      end
      if (active > 1) multi++;
    end
    chk($sformatf("one_anode_%0d", v), multi, 0);
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("lit_cycles_%0d_d%0d", v, k), lit_cnt[k], exp_lit[k] ? 8 : 0);
      if (exp_lit[k]) chk($sformatf("segs_%0d_d%0d", v, k), {24'd0, seen[k]}, {24'd0, exp_seg[k]});
    end
  endtask

  initial begin
    logic [15:0] bv, dv, eb, ed;
    int          d0;
    int          n;
    int          dark;

    glyph_lut[0] = 8'b00000011; glyph_lut[1] = 8'b10011111;
    glyph_lut[2] = 8'b00100101; glyph_lut[3] = 8'b00001101;
    glyph_lut[4] = 8'b10011001; glyph_lut[5] = 8'b01001001;
    glyph_lut[6] = 8'b01000001; glyph_lut[7] = 8'b00011111;
    glyph_lut[8] = 8'b00000001; glyph_lut[9] = 8'b00001001;

    vecs[0] = '{10000, 1'b1}; vecs[1] = '{7, 1'b0};
    vecs[2] = '{5678, 1'b0};  vecs[3] = '{16383, 1'b1};
    vecs[4] = '{100, 1'b0};   vecs[5] = '{9999, 1'b0};
    vecs[6] = '{42, 1'b0};    vecs[7] = '{0, 1'b0};
    vecs[8] = '{9000, 1'b0};  vecs[9] = '{10, 1'b0};

    // Reset state
    repeat (3) @(negedge board_clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    chk("rst_anodes", {28'd0, anodes}, 32'hF);
    chk("rst_segs", {24'd0, segs}, 32'hFF);
    reset = 1'b0;
    check_display(0);

    // Latency of a single conversion
    do_load(1234, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      bv[i-1] = busy;
      dv[i-1] = done;
      eb[i-1] = (i <= 14);
      ed[i-1] = (i == 15);
      @(negedge board_clk);
    end
    chk("busy_window", {16'd0, bv}, {16'd0, eb});
    chk("done_pulse", {16'd0, dv}, {16'd0, ed});
    check_display(1234);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      do_load(vecs[i].val, vecs[i].ovf, 1'b0);
      wait_done($sformatf("vec%0d", i));
      chk($sformatf("vec_overflow_%0d", vecs[i].val), {31'd0, overflow}, {31'd0, vecs[i].ovf});
      @(negedge board_clk);
      check_display(vecs[i].val);
    end

    // Loads during busy: newest pending value wins
    do_load(5, 1'b0, 1'b0);
    repeat (2) @(negedge board_clk);
    do_load(42, 1'b0, 1'b0);
    do_load(99, 1'b0, 1'b1);
    d0 = done_cnt;
    repeat (60) @(negedge board_clk);
    chk("pending_done_pulses", done_cnt - d0, 2);
    chk("pending_sb_empty", sb.size(), 0);
    check_display(99);

    // Reset in the middle of a conversion
    do_load(9999, 1'b0, 1'b0);
    repeat (5) @(negedge board_clk);
    reset = 1'b1;
    sb.delete();
    @(negedge board_clk);
    chk("abort_busy", {31'd0, busy}, 0);
    reset = 1'b0;
    d0 = done_cnt;
    repeat (30) @(negedge board_clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_overflow", {31'd0, overflow}, 0);
    check_display(0);

    // Decimal points, leading-zero blanking and blank_all
    dp_mask = 4'b0010;
    do_load(0, 1'b0, 1'b0);
    wait_done("dp0");
    @(negedge board_clk);
    check_display(0);
    do_load(300, 1'b0, 1'b0);
    wait_done("dp300");
    @(negedge board_clk);
    check_display(300);
    n = 0;
    while (anodes === 4'hF && n < 40) begin
      @(negedge board_clk);
      n++;
    end
    chk("lit_before_blank", {28'd0, anodes} != 32'hF, 1);
    blank_all = 1'b1;
    @(negedge board_clk);
    chk("blank_all_latency", {28'd0, anodes}, 32'hF);
    dark = 0;
    repeat (32) begin
      @(negedge board_clk);
      if (anodes !== 4'hF) dark++;
    end
    chk("blank_all_hold", dark, 0);
    blank_all = 1'b0;
    check_display(300);
    dp_mask = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", ntests, nfails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
